// File: rtl/nou_rsp_drain_pkg.sv
// Shared definitions for the response-drain block: default word width and the
// interrupt-coalescing state encoding.
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 32
`endif

package nou_rsp_drain_pkg;

    localparam int NOU_DATA_W = `NOU_XOCC_CMD_WIDTH;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_WAIT = 2'd1,
        IRQ_FIRE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/nou_rsp_drain_if.sv
// Response-FIFO read port plus the XOCC response channel toward the core.
interface nou_rsp_drain_if
    import nou_rsp_drain_pkg::*;
#(
    parameter int DATA_W = NOU_DATA_W,
    parameter int CNT_W  = 6
);
    logic              rsp_fifo_empty;
    logic [CNT_W-1:0]  rsp_fifo_cnt;
    logic              rsp_fifo_rd_en;
    logic [DATA_W-1:0] rsp_fifo_rd_data;
    logic              xocc_rsp_vld;
    logic              xocc_rsp_rdy;
    logic [DATA_W-1:0] xocc_rsp_data;

    modport master (
        input  rsp_fifo_empty, rsp_fifo_cnt, rsp_fifo_rd_data, xocc_rsp_rdy,
        output rsp_fifo_rd_en, xocc_rsp_vld, xocc_rsp_data
    );

    modport slave (
        output rsp_fifo_empty, rsp_fifo_cnt, rsp_fifo_rd_data, xocc_rsp_rdy,
        input  rsp_fifo_rd_en, xocc_rsp_vld, xocc_rsp_data
    );
endinterface

// File: rtl/nou_rsp_skid.sv
// Two-entry output buffer that hides the FIFO read latency; reads are issued
// only when a slot is guaranteed free for the returning word.
module nou_rsp_skid
    import nou_rsp_drain_pkg::*;
#(
    parameter int DATA_W = NOU_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    nou_rsp_drain_if.master  bus,
    output logic [1:0]       occ,
    output logic             inflight
);
    logic [1:0]        occ_reg;
    logic              head_reg;
    logic              tail_reg;
    logic              inflight_reg;
    logic              pop;
    logic              rd_en;
    logic [1:0]        occ_next_pop;
    logic [DATA_W-1:0] ent [SKID_DEPTH];

    // Credit check counts the slot freed by a same-cycle pop, so rdy feeds rd_en directly.
    always_comb begin
        pop          = (occ_reg != 2'd0) && bus.xocc_rsp_rdy;
        occ_next_pop = occ_reg - {1'b0, pop};
        rd_en        = !bus.rsp_fifo_empty && ((occ_next_pop + {1'b0, inflight_reg}) < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg      <= 2'd0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            inflight_reg <= 1'b0;
        end else begin
            occ_reg      <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
            inflight_reg <= rd_en;
            if (pop)
                head_reg <= ~head_reg;
            if (inflight_reg)
                tail_reg <= ~tail_reg;
        end
    end

    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_ent
        logic [DATA_W-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                entry_reg <= '0;
            else if (inflight_reg && (tail_reg == 1'(gi)))
                entry_reg <= bus.rsp_fifo_rd_data;
        end

        assign ent[gi] = entry_reg;
    end

    assign bus.rsp_fifo_rd_en = rd_en;
    assign bus.xocc_rsp_vld   = (occ_reg != 2'd0);
    assign bus.xocc_rsp_data  = ent[head_reg];
    assign occ                = occ_reg;
    assign inflight           = inflight_reg;

endmodule

// File: rtl/nou_rsp_drain.sv
// Drains completed responses to the core and coalesces them into an interrupt;
// also keeps a sticky error flag and a delivered-response counter.
module nou_rsp_drain
    import nou_rsp_drain_pkg::*;
#(
    parameter int DATA_W     = NOU_DATA_W,
    parameter int CNT_W      = 6,
    parameter int TMO_W      = 12,
    parameter int STATUS_BIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    nou_rsp_drain_if.master  bus,
    input  logic             irq_en,
    input  logic [CNT_W-1:0] irq_thresh,
    input  logic [TMO_W-1:0] irq_timeout,
    input  logic             irq_clr,
    output logic             nou_irq,
    input  logic             err_clr,
    output logic             rsp_err,
    output logic [31:0]      rsp_dlv_cnt
);
    logic [1:0]       occ;
    logic             inflight;
    logic             hs;
    logic [CNT_W:0]   avail;
    logic [CNT_W:0]   thresh_eff;
    irq_state_e       state_reg;
    logic [TMO_W-1:0] timer_reg;
    logic             irq_reg;
    logic             err_reg;
    logic [31:0]      dlv_cnt_reg;

    nou_rsp_skid #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .occ      (occ),
        .inflight (inflight)
    );

    // Words already pulled out of the FIFO still count as available to the core.
    always_comb begin
        hs         = bus.xocc_rsp_vld && bus.xocc_rsp_rdy;
        avail      = {1'b0, bus.rsp_fifo_cnt} + (CNT_W+1)'(occ) + (CNT_W+1)'(inflight);
        thresh_eff = (irq_thresh == '0) ? (CNT_W+1)'(1) : {1'b0, irq_thresh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IRQ_IDLE;
            timer_reg <= '0;
            irq_reg   <= 1'b0;
        end else if (!irq_en) begin
            state_reg <= IRQ_IDLE;
            irq_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IRQ_IDLE: begin
                    if (avail != '0) begin
                        state_reg <= IRQ_WAIT;
                        timer_reg <= '0;
                    end
                end
                IRQ_WAIT: begin
                    if (timer_reg != '1)
                        timer_reg <= timer_reg + TMO_W'(1);
                    if (avail == '0) begin
                        state_reg <= IRQ_IDLE;
                    end else if ((avail >= thresh_eff) || (timer_reg == irq_timeout)) begin
                        state_reg <= IRQ_FIRE;
                        irq_reg   <= 1'b1;
                    end
                end
                IRQ_FIRE: begin
                    if (irq_clr) begin
                        state_reg <= IRQ_IDLE;
                        irq_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IRQ_IDLE;
                    irq_reg   <= 1'b0;
                end
            endcase
        end
    end

    // A new error outranks a same-cycle clear so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg     <= 1'b0;
            dlv_cnt_reg <= 32'd0;
        end else begin
            if (hs)
                dlv_cnt_reg <= dlv_cnt_reg + 32'd1;
            if (hs && bus.xocc_rsp_data[STATUS_BIT])
                err_reg <= 1'b1;
            else if (err_clr)
                err_reg <= 1'b0;
        end
    end

    assign nou_irq     = irq_reg;
    assign rsp_err     = err_reg;
    assign rsp_dlv_cnt = dlv_cnt_reg;

endmodule

// File: tb/tb_nou_rsp_drain.sv
// Self-checking bench: FIFO model feeding the drain, scoreboard on the response
// channel, table-driven IRQ cases plus hand-written stream/backpressure/reset sequences.
module tb_nou_rsp_drain;
    import nou_rsp_drain_pkg::*;

    localparam int DATA_W = NOU_DATA_W;
    localparam int CNT_W  = 6;
    localparam int TMO_W  = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             irq_en = 1'b0;
    logic [CNT_W-1:0] irq_thresh = '0;
    logic [TMO_W-1:0] irq_timeout = '0;
    logic             irq_clr = 1'b0;
    logic             nou_irq;
    logic             err_clr = 1'b0;
    logic             rsp_err;
    logic [31:0]      rsp_dlv_cnt;

    int checks = 0;
    int failures = 0;
    int n_rsp = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] push_q[$];
    logic [DATA_W-1:0] exp_q[$];

    nou_rsp_drain_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    nou_rsp_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TMO_W(TMO_W), .STATUS_BIT(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .irq_en      (irq_en),
        .irq_thresh  (irq_thresh),
        .irq_timeout (irq_timeout),
        .irq_clr     (irq_clr),
        .nou_irq     (nou_irq),
        .err_clr     (err_clr),
        .rsp_err     (rsp_err),
        .rsp_dlv_cnt (rsp_dlv_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Response FIFO model: registered flags, read data one cycle after rd_en, shares rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            push_q.delete();
            bus.rsp_fifo_empty   <= 1'b1;
            bus.rsp_fifo_cnt     <= '0;
            bus.rsp_fifo_rd_data <= '0;
        end else begin
            if (bus.rsp_fifo_rd_en && fifo_q.size() > 0)
                bus.rsp_fifo_rd_data <= fifo_q.pop_front();
            while (push_q.size() > 0)
                fifo_q.push_back(push_q.pop_front());
            bus.rsp_fifo_empty <= (fifo_q.size() == 0);
            bus.rsp_fifo_cnt   <= CNT_W'(fifo_q.size());
        end
    end

    // Scoreboard: every handshake must match the oldest word pushed by the stimulus.
    always @(negedge clk) begin
        if (rst_n && bus.xocc_rsp_vld && bus.xocc_rsp_rdy) begin
            n_rsp++;
            $display("rsp %0d data=0x%0h", n_rsp, bus.xocc_rsp_data);
            if (exp_q.size() == 0)
                chk("unexpected_rsp", 64'(bus.xocc_rsp_data), 64'hDEAD_0000_0000);
            else
                chk("rsp_data", 64'(bus.xocc_rsp_data), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        push_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain();
        int k;
        bus.xocc_rsp_rdy = 1'b1;
        for (k = 0; k < 100; k++) begin
            if (exp_q.size() == 0 && !bus.xocc_rsp_vld && bus.rsp_fifo_empty && push_q.size() == 0)
                break;
            tick();
        end
        if (k == 100)
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    typedef struct {
        logic [CNT_W-1:0] thresh;
        logic [TMO_W-1:0] timeout;
        int               nwords;
        bit               use_clr;
        int               exp_k;
    } irq_vec_t;

    irq_vec_t vecs[6];

    initial begin
        int first_rd;
        int first_vld;
        int last_vld;
        int vld_cycles;
        int rd_cnt;
        int k;

        // Cycles counted from the push to the edge where nou_irq rises.
        vecs[0] = '{thresh: 6'd3,  timeout: 12'd100, nwords: 3, use_clr: 1'b1, exp_k: 3};
        vecs[1] = '{thresh: 6'd10, timeout: 12'd4,   nwords: 1, use_clr: 1'b1, exp_k: 7};
        vecs[2] = '{thresh: 6'd0,  timeout: 12'd50,  nwords: 1, use_clr: 1'b1, exp_k: 3};
        vecs[3] = '{thresh: 6'd5,  timeout: 12'd0,   nwords: 2, use_clr: 1'b1, exp_k: 3};
        vecs[4] = '{thresh: 6'd2,  timeout: 12'd9,   nwords: 1, use_clr: 1'b0, exp_k: 12};
        vecs[5] = '{thresh: 6'd4,  timeout: 12'd20,  nwords: 6, use_clr: 1'b1, exp_k: 3};

        bus.xocc_rsp_rdy = 1'b0;
        repeat (2) tick();
        chk("rst_vld", 64'(bus.xocc_rsp_vld), 64'd0);
        chk("rst_data", 64'(bus.xocc_rsp_data), 64'd0);
        chk("rst_rd_en", 64'(bus.rsp_fifo_rd_en), 64'd0);
        chk("rst_irq", 64'(nou_irq), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_dlv_cnt", 64'(rsp_dlv_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Back-to-back stream of 8 words with rdy held high.
        bus.xocc_rsp_rdy = 1'b1;
        for (int i = 1; i <= 8; i++)
            push_word(DATA_W'(i));
        first_rd = -1; first_vld = -1; last_vld = -1; vld_cycles = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.rsp_fifo_rd_en && first_rd < 0) first_rd = t;
            if (bus.xocc_rsp_vld) begin
                if (first_vld < 0) first_vld = t;
                last_vld = t;
                vld_cycles++;
            end
        end
        chk("b2b_first_rd_en", 64'(first_rd), 64'd1);
        chk("b2b_first_vld", 64'(first_vld), 64'd3);
        chk("b2b_vld_cycles", 64'(vld_cycles), 64'd8);
        chk("b2b_contiguous", 64'(last_vld - first_vld + 1), 64'd8);
        chk("b2b_dlv_cnt", 64'(rsp_dlv_cnt), 64'd8);
        chk("b2b_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("b2b_err_odd_words", 64'(rsp_err), 64'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_clr_plain", 64'(rsp_err), 64'd0);

        // Backpressure: 4 words, rdy low; only two reads may be issued.
        bus.xocc_rsp_rdy = 1'b0;
        for (int i = 1; i <= 4; i++)
            push_word(DATA_W'(i));
        rd_cnt = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (bus.rsp_fifo_rd_en) rd_cnt++;
            if (t >= 3) begin
                chk("bp_vld_held", 64'(bus.xocc_rsp_vld), 64'd1);
                chk("bp_data_stable", 64'(bus.xocc_rsp_data), 64'h1);
            end
        end
        chk("bp_rd_en_pops", 64'(rd_cnt), 64'd2);
        drain();
        chk("bp_dlv_cnt", 64'(rsp_dlv_cnt), 64'd12);
        bus.xocc_rsp_rdy = 1'b0;

        // IRQ coalescing table.
        foreach (vecs[v]) begin
            irq_thresh  = vecs[v].thresh;
            irq_timeout = vecs[v].timeout;
            irq_en      = 1'b1;
            for (int i = 0; i < vecs[v].nwords; i++)
                push_word(DATA_W'(32'h100 + 32'(v * 16 + i * 2)));
            for (k = 1; k <= 200; k++) begin
                tick();
                if (nou_irq) break;
            end
            chk($sformatf("irq_rise_v%0d", v), 64'(k), 64'(vecs[v].exp_k));
            if (vecs[v].use_clr) irq_clr = 1'b1;
            else                 irq_en = 1'b0;
            tick();
            irq_clr = 1'b0;
            chk($sformatf("irq_drop_v%0d", v), 64'(nou_irq), 64'd0);
            irq_en = 1'b0;
            drain();
            bus.xocc_rsp_rdy = 1'b0;
        end

        // Error set wins over a same-cycle clear.
        push_word(DATA_W'(32'h11));
        for (k = 0; k < 20; k++) begin
            if (bus.xocc_rsp_vld) break;
            tick();
        end
        chk("err_wait_vld", 64'(bus.xocc_rsp_vld), 64'd1);
        bus.xocc_rsp_rdy = 1'b1;
        err_clr = 1'b1;
        tick();
        bus.xocc_rsp_rdy = 1'b0;
        err_clr = 1'b0;
        chk("err_set_wins", 64'(rsp_err), 64'd1);
        tick();
        chk("err_sticky", 64'(rsp_err), 64'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_cleared", 64'(rsp_err), 64'd0);

        // Reset with a word buffered and a read in flight.
        for (int i = 0; i < 4; i++)
            push_word(DATA_W'(32'h50 + 32'(i)));
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_vld", 64'(bus.xocc_rsp_vld), 64'd0);
        chk("mid_rst_data", 64'(bus.xocc_rsp_data), 64'd0);
        chk("mid_rst_rd_en", 64'(bus.rsp_fifo_rd_en), 64'd0);
        chk("mid_rst_dlv_cnt", 64'(rsp_dlv_cnt), 64'd0);
        chk("mid_rst_irq", 64'(nou_irq), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.xocc_rsp_rdy = 1'b1;
        vld_cycles = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.xocc_rsp_vld) vld_cycles++;
        end
        chk("post_rst_no_stale", 64'(vld_cycles), 64'd0);
        push_word(DATA_W'(32'hA0));
        push_word(DATA_W'(32'hA2));
        drain();
        chk("post_rst_dlv_cnt", 64'(rsp_dlv_cnt), 64'd2);
        chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
